// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode types for decode_issue_ctrl: immediate formats, RV opcodes and the buffered entry.
// Entries are stored at the package-wide Xlen width; the top's XLEN parameter must match it.
package decode_pkg;

    localparam int unsigned Xlen = 32;

    typedef enum logic [2:0] {
        ExtI  = 3'b000,
        ExtS  = 3'b001,
        ExtB  = 3'b010,
        ExtU  = 3'b011,
        ExtJ  = 3'b100,
        ExtR4 = 3'b101
    } ext_sel_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpMadd   = 7'b1000011;
    localparam logic [6:0] OpMsub   = 7'b1000111;
    localparam logic [6:0] OpNmsub  = 7'b1001011;
    localparam logic [6:0] OpNmadd  = 7'b1001111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef struct packed {
        logic [Xlen-1:0] instr;
        logic [Xlen-1:0] pc;
        ext_sel_e        ext_sel;
        logic            has_imm;
        logic            illegal;
    } entry_t;

    // Every recognised opcode has instr[1:0]=11, so compressed encodings fall into default.
    function automatic entry_t make_entry(input logic [Xlen-1:0] instr, input logic [Xlen-1:0] pc);
        entry_t e;
        e.instr   = instr;
        e.pc      = pc;
        e.ext_sel = ExtI;
        e.has_imm = 1'b0;
        e.illegal = 1'b0;
        case (instr[6:0])
            OpLoad, OpImm, OpJalr, OpSystem: e.has_imm = 1'b1;
            OpStore:                         begin e.ext_sel = ExtS; e.has_imm = 1'b1; end
            OpBranch:                        begin e.ext_sel = ExtB; e.has_imm = 1'b1; end
            OpLui, OpAuipc:                  begin e.ext_sel = ExtU; e.has_imm = 1'b1; end
            OpJal:                           begin e.ext_sel = ExtJ; e.has_imm = 1'b1; end
            OpMadd, OpMsub, OpNmsub, OpNmadd: e.ext_sel = ExtR4;
            OpReg:                           e.ext_sel = ExtI;
            default:                         e.illegal = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and execute-side handshake bundle for decode_issue_ctrl.
interface decode_issue_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_ext_sel;
    logic            out_has_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_ext_sel, out_has_imm,
               out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_ext_sel, out_has_imm,
               out_illegal
    );
endinterface

// File: rtl/decode_issue_ctrl_imm_gen.sv
// Immediate generator: sign-extended RV immediate for the selected format, zero otherwise.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_instr,
    input  ext_sel_e        i_ext_sel,
    output logic [XLEN-1:0] o_imm
);
    logic [31:0] w_i;
    logic        w_unused_opcode;

    assign w_i             = i_instr[31:0];
    assign w_unused_opcode = ^w_i[6:0];

    always_comb begin
        o_imm = '0;
        unique case (i_ext_sel)
            ExtI:    o_imm = XLEN'($signed(w_i[31:20]));
            ExtS:    o_imm = XLEN'($signed({w_i[31:25], w_i[11:7]}));
            ExtB:    o_imm = XLEN'($signed({w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0}));
            ExtU:    o_imm = XLEN'($signed({w_i[31:12], 12'b0}));
            ExtJ:    o_imm = XLEN'($signed({w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0}));
            default: o_imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_issue_ctrl.sv
// Two-entry (main + skid) decode/issue buffer with registered in_ready and 1-cycle latency.
// Optional perf counters (stall_cnt, illegal_cnt) are enabled by defining DECODE_ISSUE_PERF_EN.
module decode_issue_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    decode_issue_if.slave bus
`ifdef DECODE_ISSUE_PERF_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   illegal_cnt
`endif
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e          r_state, w_state_d;
    entry_t          r_main, r_skid, w_main_d, w_skid_d, w_new;
    logic            r_in_ready;
    logic            w_in_ready, w_out_valid, w_accept, w_issue;
    logic [XLEN-1:0] w_imm;

    assign w_in_ready  = r_in_ready & ~rst;
    assign w_out_valid = (r_state != StEmpty);
    assign w_accept    = bus.in_valid & w_in_ready & ~flush;
    assign w_issue     = w_out_valid & bus.out_ready;
    assign w_new       = make_entry(Xlen'(bus.in_instr), Xlen'(bus.in_pc));

    // In FULL in_ready is low, so an accept can only coincide with EMPTY or ONE.
    always_comb begin
        w_state_d = r_state;
        w_main_d  = r_main;
        w_skid_d  = r_skid;
        if (flush) begin
            w_state_d = StEmpty;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        w_state_d = StOne;
                        w_main_d  = w_new;
                    end
                end
                StOne: begin
                    if (w_accept && w_issue) begin
                        w_main_d = w_new;
                    end else if (w_accept) begin
                        w_state_d = StFull;
                        w_skid_d  = w_new;
                    end else if (w_issue) begin
                        w_state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (w_issue) begin
                        w_state_d = StOne;
                        w_main_d  = r_skid;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StEmpty;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_main     <= w_main_d;
            r_skid     <= w_skid_d;
            r_in_ready <= (w_state_d != StFull);
        end
    end

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .i_instr  (r_main.instr[XLEN-1:0]),
        .i_ext_sel(r_main.ext_sel),
        .o_imm    (w_imm)
    );

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_instr   = r_main.instr[XLEN-1:0];
    assign bus.out_pc      = r_main.pc[XLEN-1:0];
    assign bus.out_ext_sel = r_main.ext_sel;
    assign bus.out_has_imm = r_main.has_imm;
    assign bus.out_illegal = r_main.illegal;
    assign bus.out_imm     = r_main.has_imm ? w_imm : '0;

`ifdef DECODE_ISSUE_PERF_EN
    logic [31:0] r_stall_cnt, r_illegal_cnt;

    // Stalls count even in a flush cycle; only a real (unflushed) issue counts as illegal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_issue && !flush && r_main.illegal) r_illegal_cnt <= r_illegal_cnt + 32'd1;
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign illegal_cnt = r_illegal_cnt;
`endif
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: decode vector table, directed handshake/flush/reset sequences,
// and random traffic against a queue-based reference model.
module tb_decode_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    decode_issue_if #(.XLEN(32)) bus ();

`ifdef DECODE_ISSUE_PERF_EN
    logic [31:0] stall_cnt, illegal_cnt;
    decode_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .stall_cnt(stall_cnt), .illegal_cnt(illegal_cnt)
    );
`else
    decode_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );
`endif

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ext;
        logic        has;
        logic        ill;
        logic [31:0] imm;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    vec_t       tbl[14];
    ent_t       q[$];
    logic [6:0] pool[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << n;
        return v[n-1] ? (v | m) : v;
    endfunction

    // Reference decode written from the opcode tables and RV immediate bit layouts.
    function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] ext,
                                    output logic has, output logic ill, output logic [31:0] imm);
        ext = 3'd0; has = 1'b0; ill = 1'b0; imm = 32'd0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin has = 1; imm = sext(ins >> 20, 12); end
            7'h23: begin
                ext = 3'd1; has = 1;
                imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
            end
            7'h63: begin
                ext = 3'd2; has = 1;
                imm = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
                           | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
            end
            7'h37, 7'h17: begin ext = 3'd3; has = 1; imm = ins & 32'hFFFF_F000; end
            7'h6f: begin
                ext = 3'd4; has = 1;
                imm = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12)
                           | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
            end
            7'h43, 7'h47, 7'h4b, 7'h4f: ext = 3'd5;
            7'h33: ext = 3'd0;
            default: ill = 1'b1;
        endcase
    endfunction

    initial begin
        logic [2:0]  e_ext;
        logic        e_has, e_ill, acc, iss;
        logic [31:0] e_imm, r, pc_ctr;
        int          mstall, mill;

        tbl[0]  = '{32'h0050_0093, 3'd0, 1'b1, 1'b0, 32'h0000_0005};
        tbl[1]  = '{32'hfff0_0093, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        tbl[2]  = '{32'h0051_2423, 3'd1, 1'b1, 1'b0, 32'h0000_0008};
        tbl[3]  = '{32'h0000_0863, 3'd2, 1'b1, 1'b0, 32'h0000_0010};
        tbl[4]  = '{32'hFE00_0FE3, 3'd2, 1'b1, 1'b0, 32'hFFFF_FFFE};
        tbl[5]  = '{32'h0080_00ef, 3'd4, 1'b1, 1'b0, 32'h0000_0008};
        tbl[6]  = '{32'h1234_50b7, 3'd3, 1'b1, 1'b0, 32'h1234_5000};
        tbl[7]  = '{32'h0000_1097, 3'd3, 1'b1, 1'b0, 32'h0000_1000};
        tbl[8]  = '{32'h0020_81b3, 3'd0, 1'b0, 1'b0, 32'h0000_0000};
        tbl[9]  = '{32'h0000_0043, 3'd5, 1'b0, 1'b0, 32'h0000_0000};
        tbl[10] = '{32'h0000_0000, 3'd0, 1'b0, 1'b1, 32'h0000_0000};
        tbl[11] = '{32'h0050_0091, 3'd0, 1'b0, 1'b1, 32'h0000_0000};
        tbl[12] = '{32'h0000_0073, 3'd0, 1'b1, 1'b0, 32'h0000_0000};
        tbl[13] = '{32'h0040_80e7, 3'd0, 1'b1, 1'b0, 32'h0000_0004};
        pool = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                 7'h6f, 7'h43, 7'h4f, 7'h33, 7'h00, 7'h01, 7'h7f, 7'h0b};

        // Reset: in_ready low while rst is high, then empty and ready.
        idle();
        rst = 1'b1;
        tick();
        chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
`ifdef DECODE_ISSUE_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_illegal_cnt", illegal_cnt, 32'd0);
`endif

        // Decode table: single accept, 1-cycle latency, then drain.
        for (int i = 0; i < 14; i++) begin
            bus.out_ready = 1'b1;
            offer(tbl[i].instr, 32'h1000 + 32'(4 * i));
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("tbl%0d_instr", i), bus.out_instr, tbl[i].instr);
            chk($sformatf("tbl%0d_pc", i), bus.out_pc, 32'h1000 + 32'(4 * i));
            chk($sformatf("tbl%0d_ext", i), 32'(bus.out_ext_sel), 32'(tbl[i].ext));
            chk($sformatf("tbl%0d_has", i), 32'(bus.out_has_imm), 32'(tbl[i].has));
            chk($sformatf("tbl%0d_ill", i), 32'(bus.out_illegal), 32'(tbl[i].ill));
            chk($sformatf("tbl%0d_imm", i), bus.out_imm, tbl[i].imm);
            tick();
            chk($sformatf("tbl%0d_drained", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure fill, hold third offer, then drain in order (sw, beq, jal).
        idle();
        offer(32'h0051_2423, 32'h200);
        tick();
        chk("bp_one_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_one_valid", 32'(bus.out_valid), 32'd1);
        offer(32'h0000_0863, 32'h204);
        tick();
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        offer(32'h0080_00ef, 32'h208);
        tick();
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_ext", 32'(bus.out_ext_sel), 32'd1);
        chk("bp_hold_pc", bus.out_pc, 32'h200);
        bus.out_ready = 1'b1;
        #1;
        chk("full_issue_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("order_beq_ext", 32'(bus.out_ext_sel), 32'd2);
        chk("order_beq_pc", bus.out_pc, 32'h204);
        chk("after_full_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("order_jal_ext", 32'(bus.out_ext_sel), 32'd4);
        chk("order_jal_pc", bus.out_pc, 32'h208);
        chk("order_jal_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk("order_drained", 32'(bus.out_valid), 32'd0);

        // Flush while FULL with a same-cycle offer.
        idle();
        offer(32'h0050_0093, 32'h300);
        tick();
        offer(32'h0051_2423, 32'h304);
        tick();
        offer(32'h0080_00ef, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("flush_nothing", 32'(bus.out_valid), 32'd0);
        offer(32'h1234_50b7, 32'h30c);
        tick();
        bus.in_valid = 1'b0;
        chk("post_flush_pc", bus.out_pc, 32'h30c);
        chk("post_flush_valid", 32'(bus.out_valid), 32'd1);
        tick();

        // Illegal opcode with 3 backpressure cycles.
        do_reset();
        offer(32'h0000_0000, 32'h400);
        tick();
        bus.in_valid = 1'b0;
        chk("ill_flag", 32'(bus.out_illegal), 32'd1);
        chk("ill_has", 32'(bus.out_has_imm), 32'd0);
        chk("ill_imm", bus.out_imm, 32'd0);
        repeat (3) tick();
        bus.out_ready = 1'b1;
        tick();
        chk("ill_issued", 32'(bus.out_valid), 32'd0);
`ifdef DECODE_ISSUE_PERF_EN
        chk("ill_stall_cnt", stall_cnt, 32'd3);
        chk("ill_illegal_cnt", illegal_cnt, 32'd1);
`endif

        // Random traffic against a queue model.
        do_reset();
        pc_ctr = 32'h8000;
        mstall = 0;
        mill   = 0;
        for (int c = 0; c < 600; c++) begin
            r             = $urandom();
            bus.in_valid  = ($urandom_range(0, 9) < 6);
            bus.in_instr  = {r[31:7], pool[$urandom_range(0, 15)]};
            bus.in_pc     = pc_ctr;
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 39) == 0);
            #1;
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                ref_dec(q[0].instr, e_ext, e_has, e_ill, e_imm);
                chk("rnd_instr", bus.out_instr, q[0].instr);
                chk("rnd_pc", bus.out_pc, q[0].pc);
                chk("rnd_ext", 32'(bus.out_ext_sel), 32'(e_ext));
                chk("rnd_has", 32'(bus.out_has_imm), 32'(e_has));
                chk("rnd_ill", 32'(bus.out_illegal), 32'(e_ill));
                chk("rnd_imm", bus.out_imm, e_imm);
            end
            if (q.size() > 0 && !bus.out_ready) mstall++;
            if (flush) begin
                q.delete();
            end else begin
                acc = bus.in_valid && (q.size() < 2);
                iss = (q.size() > 0) && bus.out_ready;
                if (iss) begin
                    ref_dec(q[0].instr, e_ext, e_has, e_ill, e_imm);
                    if (e_ill) mill++;
                    void'(q.pop_front());
                end
                if (acc) begin
                    q.push_back('{bus.in_instr, pc_ctr});
                    pc_ctr = pc_ctr + 32'd4;
                end
            end
            tick();
        end
`ifdef DECODE_ISSUE_PERF_EN
        chk("rnd_stall_cnt", stall_cnt, 32'(mstall));
        chk("rnd_illegal_cnt", illegal_cnt, 32'(mill));
`endif

        // Reset while FULL.
        idle();
        offer(32'h0050_0093, 32'h500);
        tick();
        offer(32'h0051_2423, 32'h504);
        tick();
        offer(32'h0080_00ef, 32'h508);
        rst = 1'b1;
        #1;
        chk("rst_full_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_full_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_full_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef DECODE_ISSUE_PERF_EN
        chk("rst_full_stall_cnt", stall_cnt, 32'd0);
        chk("rst_full_illegal_cnt", illegal_cnt, 32'd0);
`endif
        bus.out_ready = 1'b1;
        tick();
        chk("rst_full_nothing", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning instruction and PC width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  discard all buffered instructions.
REQ-005 SHALL have port in_valid  input  1  fetch offers an instruction.
REQ-006 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-007 SHALL have port in_instr  input  XLEN  fetched instruction.
REQ-008 SHALL have port in_pc  input  XLEN  PC of in_instr.
REQ-009 SHALL have port out_valid  output  1  decoded instruction available.
REQ-010 SHALL have port out_ready  input  1  execute accepts this cycle.
REQ-011 SHALL have ports out_instr and out_pc  output  XLEN  the issued instruction and its PC.
REQ-012 SHALL have port out_imm  output  XLEN  immediate produced by the immediate generator from out_instr.
REQ-013 SHALL have port out_ext_sel  output  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 R4.
REQ-014 SHALL have ports out_has_imm and out_illegal  output  1 each  immediate used; opcode unrecognised.

Function
REQ-015 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-016 SHALL hold a 2-entry buffer (main, skid); states EMPTY, ONE, FULL by occupancy.
REQ-017 SHALL drive in_ready = !FULL, from a register only; no combinational in_valid->in_ready or out_ready->in_ready path.
REQ-018 SHALL give latency of 1 cycle: an instruction accepted in cycle N appears with out_valid in cycle N+1 if the buffer was EMPTY or the head was issued in cycle N.
REQ-019 SHALL preserve strict program order; no duplication or loss of an instruction absent flush.
REQ-020 SHALL hold out_* stable while out_valid && !out_ready.
REQ-021 SHALL apply these state transitions: EMPTY->ONE on accept; ONE->FULL on accept without issue; ONE->EMPTY on issue without accept; FULL->ONE on issue; and when accept and issue fall in the same cycle, occupancy is unchanged and the new instruction goes behind the remaining one.
REQ-022 SHALL decode opcode instr[6:0] at accept and store the result alongside the entry:
- I: 0000011, 0010011, 1100111, 1110011
- S: 0100011
- B: 1100011
- U: 0110111, 0010111
- J: 1101111
- R4: 1000011, 1000111, 1001011, 1001111
REQ-023 SHALL set has_imm=1 for I, S, B, U and J, and has_imm=0 for R4.
REQ-024 SHALL, for opcode 0110011 (R), set ext_sel=000, has_imm=0, illegal=0.
REQ-025 SHALL, for any other opcode or instr[1:0]!=11, set illegal=1, ext_sel=000, has_imm=0, and still issue the entry normally.
REQ-026 SHALL, on flush, clear occupancy to EMPTY in the next cycle, ignore any same-cycle in_valid, and count no same-cycle out transfer toward any statistic; flush has priority over accept and issue.
REQ-027 SHALL drive out_imm = 0 whenever out_has_imm=0.

Reset
REQ-028 SHALL, with rst high at a clk edge, set occupancy EMPTY, out_valid=0, in_ready=1, all stored instr/pc/decode fields 0, and counters 0.
REQ-029 SHALL give rst priority over flush and all transfers; asserting rst mid-operation discards buffered entries identically.
REQ-030 SHALL drive in_ready=0 during the cycle rst is asserted.

Configuration
REQ-031 SHALL use macro DECODE_ISSUE_PERF_EN. When defined, it adds outputs stall_cnt (32) and illegal_cnt (32):
- stall_cnt increments each cycle with out_valid && !out_ready.
- illegal_cnt increments on each issued entry with illegal=1.
- both wrap at 2^32.
- flush does not clear them; only rst does.
REQ-032 SHALL, when DECODE_ISSUE_PERF_EN is undefined, have no counter ports or logic, with all other behaviour identical.

Structure
REQ-033 SHALL place the ext_sel encodings (enum), opcode constants, and a decoded-entry struct {instr, pc, ext_sel, has_imm, illegal} in the shared package decode_pkg.
REQ-034 SHALL instantiate imm_gen as the single sub-module on the head entry (out_instr, out_ext_sel); no other sub-modules.

Verification
REQ-035 SHALL cover: single instr 0x00500093 (addi) accepted, out_ready=1 -> next cycle out_valid=1, ext_sel=000, has_imm=1, out_imm=0x00000005.
REQ-036 SHALL cover: out_ready=0, three back-to-back sw/beq/jal offers -> two accepted, in_ready=0 after the second, third held; release out_ready -> order sw(001), beq(010), jal(100).
REQ-037 SHALL cover: FULL with simultaneous issue and in_valid -> in_ready=0 that cycle, ONE next, third accepted the cycle after, no loss.
REQ-038 SHALL cover: flush with in_valid=1 while FULL -> next cycle out_valid=0, in_ready=1, flushed and same-cycle instructions never appear.
REQ-039 SHALL cover: opcode 0000000 -> out_illegal=1, has_imm=0, out_imm=0; with DECODE_ISSUE_PERF_EN, illegal_cnt=1 after issue and stall_cnt equal to backpressure cycles.
REQ-040 SHALL cover: rst asserted while FULL -> next cycle out_valid=0, in_ready=1, counters 0.
